uart_receiver: RTL and testbench
================================

# uart_receiver

- Serial-in counterpart of the UART emitter.
- Deserialises 8N1 frames arriving on the `rx` pin into bytes and holds each byte in a one-entry output register with a valid/ack handshake.
- Sits beside the emitter inside the IO memory region; the IO memory exposes `dataOut`/status as read-only locations and pulses `ack` when the CPU reads the data location.

## Interface
Parameters:
- `CLKS_PER_BIT`, 234, clock cycles per bit period (27 MHz / 115200); legal values ≥ 8.

Ports:
- `clk`  input  1  single system clock, all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `ack`  input  1  one-cycle pulse; consumer has taken `dataOut`.
- `clr`  input  1  one-cycle pulse; clears `frameErr` and `overrun`.
- `dataOut`  output  8  last accepted byte.
- `valid`  output  1  `dataOut` holds an unconsumed byte.
- `frameErr`  output  1  sticky; a stop bit was sampled low.
- `overrun`  output  1  sticky; a byte completed while `valid` was high and was dropped.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. All decisions use `rx_s`.
- States:
  - IDLE: on `rx_s==0`, go to START and clear the counter.
  - START: count H = CLKS_PER_BIT/2 (integer) cycles, then sample. If `rx_s==0`, go to DATA with the bit index at 0. If `rx_s==1`, this is a false start: return to IDLE with no flags changed.
  - DATA: count CLKS_PER_BIT cycles, then sample into the shift register LSB first and increment the index. After bit 7, go to STOP.
  - STOP: count CLKS_PER_BIT cycles, then sample.
    - `rx_s==1`: deliver the byte and go to IDLE.
    - `rx_s==0`: set `frameErr`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from producing frames.
- Delivery:
  - If `valid==0`, or `ack` is asserted in the same cycle: load `dataOut` and set `valid=1`.
  - Otherwise keep `dataOut` unchanged, drop the new byte, and set `overrun=1`.
- `ack` with no delivery in the same cycle: `valid` goes to 0 and `dataOut` is unchanged. `ack` while `valid==0` is ignored.
- `clr` clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- Counter width is clog2(CLKS_PER_BIT). The counter restarts at 0 on every state entry and never wraps mid-period.

## Timing
- Reset values: `dataOut`=0x00, `valid`=0, `frameErr`=0, `overrun`=0, `busy`=0. The FSM resets to IDLE and the synchronizer flops reset to 1.
- Reset applied mid-frame aborts the frame immediately. The first start bit recognised after reset must begin after reset deasserts.
- Let T be the first cycle with `rx_s==0` in IDLE, which is 2 cycles after the pin falls. Let C = CLKS_PER_BIT.
  - Start bit sampled at T+H.
  - Data bit i sampled at T+H+(i+1)·C.
  - Stop bit sampled at T+H+9·C.
  - `valid` (or `frameErr`/`overrun`) is visible at T+H+9·C+1.
  - The FSM is back in IDLE at the same cycle and can detect a new start the next cycle.
- `ack`/`clr` take effect on the outputs in the cycle after the pulse.
- `busy` rises at T+1.

## Structure
- Shared package `scpu_uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK);
  - the default CLKS_PER_BIT (234), shared with the emitter;
  - the frame constants (8 data bits, 1 stop bit).
- One sub-module, `sync2`: a 2-flop synchronizer with parameterised reset value. It is reused by future IO inputs.

## Test plan
Use CLKS_PER_BIT=16 unless noted.
- Send 0xA5 at the nominal rate → `dataOut`=0xA5 and `valid`=1 exactly at T+8+145. No flags set.
- Drive `rx` low for 4 cycles, then high → no `valid`; `busy` falls after the start sample; no flags set.
- Send frame 0x3C with stop bit 0 and hold `rx` low for 40 cycles, then high → `frameErr`=1 and `valid`=0. No frame is recognised until `rx` returns high. `clr` then gives `frameErr`=0.
- Send 0x11 then 0x22 with no `ack` → `dataOut`=0x11, `valid`=1, `overrun`=1.
- Pulse `ack` in the exact cycle the second byte 0x22 is delivered → `dataOut`=0x22, `valid`=1, `overrun`=0.
- Assert `rst` at bit 4 of a 0xFF frame, release it, then send 0x5A → all outputs are at reset values during reset. Only 0x5A is delivered; there is no spurious byte or `frameErr`.

Source files
------------

// File: rtl/scpu_uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit period and frame shape.
// Imported by the receiver and intended to be shared with the emitter.
package scpu_uart_pkg;

  // 27 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 234;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Start bit is checked half a bit period in, so later samples land mid-bit.
  function automatic int half_period(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VALUE lets idle-high lines such as a UART rx come out of reset idle.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RESET_VALUE;
      sync_reg <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: deserialises rx into bytes held in a one-entry output register
// with a valid/ack handshake, plus sticky framing-error and overrun flags.
module uart_receiver
  import scpu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ack,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 valid,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_period(CLKS_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 deliver;
  logic                 stop_err;

  // Reset to idle-high so a reset never manufactures a start bit.
  sync2 #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    deliver    = 1'b0;
    stop_err   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            idx_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_err   = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // A line held low must return high before another start is accepted.
      ST_BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output register: later assignments take priority, so flag sets beat clr.
  always_comb begin
    data_next      = data_reg;
    valid_next     = valid_reg;
    frame_err_next = frame_err_reg;
    overrun_next   = overrun_reg;

    if (clr) begin
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;
    end

    if (ack && valid_reg) begin
      valid_next = 1'b0;
    end

    if (deliver) begin
      if (!valid_reg || ack) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end

    if (stop_err) begin
      frame_err_next = 1'b1;
    end
  end

  assign dataOut  = data_reg;
  assign valid    = valid_reg;
  assign frameErr = frame_err_reg;
  assign overrun  = overrun_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with CLKS_PER_BIT=16: stimulus pushes expected
// bytes and delivery cycles into a queue, a monitor pops and compares on each new byte.
module tb_uart_receiver;

  localparam int C = 16;
  localparam int H = C / 2;
  // pin falls at cycle p -> byte visible at p + 2 + H + 9*C + 1
  localparam int DELIVER_OFS = 2 + H + 9 * C + 1;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ack;
  logic       clr;
  logic [7:0] dataOut;
  logic       valid;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  int   cyc;
  int   errors;
  int   checks;
  exp_t sb[$];

  uart_receiver #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .ack     (ack),
    .clr     (clr),
    .dataOut (dataOut),
    .valid   (valid),
    .frameErr(frameErr),
    .overrun (overrun),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame; optionally pulses ack in the exact cycle the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low,
                            input bit ack_at_stop, input bit expect_byte, output int p);
    @(posedge clk);
    #1 rx = 1'b0;
    p = cyc;
    if (expect_byte) sb.push_back(exp_t'{b, p + DELIVER_OFS});
    cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(C);
    end
    rx = stop_bit;
    if (ack_at_stop) begin
      cycles(2 + H);
      ack = 1'b1;
      cycles(1);
      ack = 1'b0;
      cycles(C - 3 - H);
    end else begin
      cycles(C);
    end
    if (!stop_bit) cycles(extra_low);
    rx = 1'b1;
  endtask

  // Monitor: a new byte is a rising valid or a changed dataOut while valid stays high.
  logic       valid_prev;
  logic [7:0] data_prev;
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
      data_prev  = 8'h00;
    end else begin
      if (valid && (!valid_prev || dataOut != data_prev)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no delivery (cycle %0d)", dataOut, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("rx byte 0x%02h at cycle %0d (expected 0x%02h at %0d)", dataOut, cyc, e.data, e.cycle);
          check("byte_data", {24'h0, dataOut}, {24'h0, e.data});
          check("byte_cycle", cyc, e.cycle);
        end
      end
      valid_prev = valid;
      data_prev  = dataOut;
    end
  end

  initial begin
    int p;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    clr = 1'b0;
    cycles(3);
    @(negedge clk);
    check("reset_data", {24'h0, dataOut}, 32'h0);
    check("reset_valid", valid, 1'b0);
    check("reset_frameErr", frameErr, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cycles(5);

    // nominal byte with exact delivery timing
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b1, p);
    @(negedge clk);
    check("a5_valid", valid, 1'b1);
    check("a5_frameErr", frameErr, 1'b0);
    check("a5_overrun", overrun, 1'b0);
    pulse_ack();
    check("ack_clears_valid", valid, 1'b0);
    check("ack_keeps_data", {24'h0, dataOut}, 32'hA5);

    // false start: four low cycles
    @(posedge clk);
    #1 rx = 1'b0;
    p = cyc;
    cycles(4);
    rx = 1'b1;
    wait_to_cycle(p + 2 + H);
    check("false_start_busy_before", busy, 1'b1);
    wait_to_cycle(p + 3 + H);
    check("false_start_busy_after", busy, 1'b0);
    cycles(C);
    check("false_start_valid", valid, 1'b0);
    check("false_start_frameErr", frameErr, 1'b0);

    // stop bit low, line held low 40 more cycles
    send_frame(8'h3C, 1'b0, 40, 1'b0, 1'b0, p);
    check("break_frameErr", frameErr, 1'b1);
    check("break_valid", valid, 1'b0);
    wait_to_cycle(p + 9 * C + C + 40 + 2);
    check("break_busy_held", busy, 1'b1);
    wait_to_cycle(p + 9 * C + C + 40 + 3);
    check("break_busy_released", busy, 1'b0);
    pulse_clr();
    check("clr_frameErr", frameErr, 1'b0);

    // overrun: two bytes, no ack
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b1, p);
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0, p);
    @(negedge clk);
    check("ovr_data", {24'h0, dataOut}, 32'h11);
    check("ovr_valid", valid, 1'b1);
    check("ovr_overrun", overrun, 1'b1);
    pulse_clr();
    check("clr_overrun", overrun, 1'b0);

    // ack coincident with delivery: accepted, no overrun
    send_frame(8'h22, 1'b1, 0, 1'b1, 1'b1, p);
    @(negedge clk);
    check("ack_same_data", {24'h0, dataOut}, 32'h22);
    check("ack_same_valid", valid, 1'b1);
    check("ack_same_overrun", overrun, 1'b0);
    pulse_ack();

    // reset mid-frame, then a clean byte
    fork
      send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0, p);
      begin
        cycles(1 + 5 * C + 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data", {24'h0, dataOut}, 32'h0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_flags", {frameErr, overrun}, 2'b00);
        cycles(3);
        rst = 1'b0;
      end
    join
    cycles(20);
    send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b1, p);
    @(negedge clk);
    check("post_rst_valid", valid, 1'b1);
    check("post_rst_frameErr", frameErr, 1'b0);
    check("post_rst_overrun", overrun, 1'b0);

    cycles(20);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
